e_mdu_pipe: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the E stage, the next generation of the fixed-latency MDU. It adds configurable mult/div latency and operand width, multiply-accumulate/subtract modes, MIPS-exact signed division, a defined divide-by-zero result, and a cancel input so a later exception/interrupt stage can kill an in-flight operation. The stall unit consumes start/busy exactly as before.

---
 rtl/e_mdu_pipe_if.sv | 24 ++
 rtl/e_mdu_pipe.sv | 132 +++++++++++++
 tb/tb_e_mdu_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pipe_if.sv
// rtl/e_mdu_pipe_if.sv - E-stage multiply/divide unit operation and result bundle
interface e_mdu_pipe_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, d1, d2, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, d1, d2, cancel,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/e_mdu_pipe.sv
// rtl/e_mdu_pipe.sv - parametrised multi-cycle multiply/divide unit with accumulate and cancel
module e_mdu_pipe #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   e_mdu_pipe_if.slave  bus
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int TW   = 2 * WIDTH;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic              is_mul, is_div;
   logic signed [TW-1:0] sext_a, sext_b, sprod;
   logic [TW-1:0]     uprod, acc, result;
   logic [WIDTH-1:0]  num, den, den_nz, uq, ur, quot, rem;

   // Operation decode of the live op input for launch qualification
   always_comb begin
      is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || (bus.op == OP_MADD) ||
               (bus.op == OP_MADDU) || (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
      is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   end

   // Result datapath, driven purely from the latched operands and current HI/LO
   always_comb begin
      sext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      sext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      sprod  = sext_a * sext_b;
      uprod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      acc    = {hi_q, lo_q};
      // Signed division runs on magnitudes; min/-1 falls out naturally as min, remainder 0
      num    = (op_q == OP_DIV && a_q[WIDTH-1]) ? -a_q : a_q;
      den    = (op_q == OP_DIV && b_q[WIDTH-1]) ? -b_q : b_q;
      den_nz = (den == '0) ? WIDTH'(1) : den;
      uq     = num / den_nz;
      ur     = num % den_nz;
      quot   = (op_q == OP_DIV && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
      rem    = (op_q == OP_DIV && a_q[WIDTH-1]) ? -ur : ur;
      result = acc;
      case (op_q)
         OP_MULT:  result = sprod;
         OP_MULTU: result = uprod;
         OP_MADD:  result = acc + sprod;
         OP_MADDU: result = acc + uprod;
         OP_MSUB:  result = acc - sprod;
         OP_MSUBU: result = acc - uprod;
         OP_DIV, OP_DIVU: begin
            if (b_q == '0) result = {a_q, {WIDTH{1'b1}}};
            else           result = {rem, quot};
         end
         default:  result = acc;
      endcase
   end

   // Next-state: cancel beats commit/countdown, which beats launch and HI/LO moves
   always_comb begin
      cnt_d  = cnt_q;
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      if (bus.cancel) begin
         cnt_d = '0;
      end else if (cnt_q > CW'(1)) begin
         cnt_d = cnt_q - CW'(1);
      end else if (cnt_q == CW'(1)) begin
         cnt_d  = '0;
         hi_d   = result[TW-1:WIDTH];
         lo_d   = result[WIDTH-1:0];
         done_d = 1'b1;
      end else if (bus.start && (is_mul || is_div)) begin
         op_d  = bus.op;
         a_d   = bus.d1;
         b_d   = bus.d2;
         cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (bus.op == OP_MTHI) begin
         hi_d = bus.d1;
      end else if (bus.op == OP_MTLO) begin
         lo_d = bus.d1;
      end
   end

   // State registers; reset discards any in-flight operation
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign bus.busy = (cnt_q != '0);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_e_mdu_pipe.sv
// tb/tb_e_mdu_pipe.sv - self-checking bench for e_mdu_pipe against a behavioural model
module tb_e_mdu_pipe;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   e_mdu_pipe_if #(.WIDTH(32)) bus ();
   e_mdu_pipe_if #(.WIDTH(32)) bus1 ();

   e_mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   e_mdu_pipe #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi, m_lo;
   logic [3:0]  ops [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      logic [63:0] ua = {32'h0, a};
      logic [63:0] ub = {32'h0, b};
      longint q, r;
      logic [63:0] uq, ur;
      case (op)
         4'd1:  return 64'(sa * sb);
         4'd2:  return ua * ub;
         4'd9:  return acc + 64'(sa * sb);
         4'd10: return acc + ua * ub;
         4'd11: return acc - 64'(sa * sb);
         4'd12: return acc - ua * ub;
         4'd3: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: return acc;
      endcase
   endfunction

   task automatic mdu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input string tag);
      logic [63:0] exp;
      int n, cyc, dones;
      exp = ref_op(op, a, b, {m_hi, m_lo});
      n = (op == 4'd3 || op == 4'd4) ? 10 : 5;
      bus.start = 1'b1; bus.op = op; bus.d1 = a; bus.d2 = b;
      tick();
      bus.start = 1'b0; bus.op = 4'd0;
      cyc = 0;
      dones = 0;
      while (bus.busy === 1'b1 && cyc < 40) begin
         dones += int'(bus.done);
         cyc++;
         if (disturb && cyc == 2) begin
            bus.op = 4'd8; bus.d1 = 32'h1;
         end else if (disturb && cyc == 3) begin
            chk({tag, "_mtlo_blocked"}, 64'(bus.lo), 64'(m_lo));
            bus.start = 1'b1; bus.op = 4'd1; bus.d1 = $urandom; bus.d2 = $urandom;
         end else begin
            bus.start = 1'b0; bus.op = 4'd0;
            if (disturb) begin bus.d1 = $urandom; bus.d2 = $urandom; end
         end
         tick();
      end
      bus.start = 1'b0; bus.op = 4'd0;
      chk({tag, "_busy_len"}, 64'(cyc), 64'(n));
      chk({tag, "_done_early"}, 64'(dones), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd1);
      chk({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      tick();
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      bus.op = op; bus.d1 = v;
      tick();
      bus.op = 4'd0;
      if (op == 4'd7) m_hi = v; else m_lo = v;
      chk("mt_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      chk("mt_busy", 64'(bus.busy), 64'd0);
      chk("mt_done", 64'(bus.done), 64'd0);
   endtask

   task automatic cancel_at(input int k, input string tag);
      bus.start = 1'b1; bus.op = 4'd1; bus.d1 = 32'd2; bus.d2 = 32'd3;
      tick();
      bus.start = 1'b0; bus.op = 4'd0;
      for (int i = 1; i < k; i++) tick();
      chk({tag, "_busy_before"}, 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
      tick();
      chk({tag, "_done_after"}, 64'(bus.done), 64'd0);
      chk({tag, "_hilo_after"}, {bus.hi, bus.lo}, {m_hi, m_lo});
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 4'd0; bus.d1 = '0; bus.d2 = '0; bus.cancel = 1'b0;
      bus1.start = 1'b0; bus1.op = 4'd0; bus1.d1 = '0; bus1.d2 = '0; bus1.cancel = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

      mdu_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, "mult");
      chk("mult_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
      mdu_op(4'd4, 32'd7, 32'd2, 1'b0, "divu");
      chk("divu_const", {bus.hi, bus.lo}, 64'h00000001_00000003);
      mdu_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
      chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
      mdu_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
      chk("div_ovf_const", {bus.hi, bus.lo}, 64'h00000000_80000000);
      mdu_op(4'd3, 32'h00001234, 32'd0, 1'b0, "div_zero");
      chk("div_zero_const", {bus.hi, bus.lo}, 64'h00001234_FFFFFFFF);
      mt(4'd7, 32'h0);
      mdu_op(4'd10, 32'd1, 32'd1, 1'b0, "maddu_carry");
      chk("maddu_const", {bus.hi, bus.lo}, 64'h00000001_00000000);

      cancel_at(3, "cancel3");
      cancel_at(5, "cancel5");

      bus.start = 1'b1; bus.op = 4'd3; bus.d1 = 32'd100; bus.d2 = 32'd7;
      tick();
      bus.start = 1'b0; bus.op = 4'd0;
      for (int i = 1; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rstmid_busy", 64'(bus.busy), 64'd0);
      chk("rstmid_done", 64'(bus.done), 64'd0);
      mt(4'd7, 32'hAAAA5555);
      chk("mthi_const", 64'(bus.hi), 64'hAAAA5555);

      mt(4'd8, 32'h5A5A0F0F);
      mdu_op(4'd3, $urandom, $urandom_range(1, 1000), 1'b1, "blocked");

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'h0;
         else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 17);
         if ($urandom_range(0, 4) == 0) mt($urandom_range(0, 1) ? 4'd7 : 4'd8, $urandom);
         mdu_op(ops[$urandom_range(0, 7)], a, b, 1'b0, "rand");
      end

      bus1.start = 1'b1; bus1.op = 4'd1; bus1.d1 = 32'd7; bus1.d2 = 32'hFFFFFFFA;
      tick();
      bus1.start = 1'b0; bus1.op = 4'd0;
      chk("p1_mult_busy", 64'(bus1.busy), 64'd1);
      tick();
      chk("p1_mult_fall", 64'(bus1.busy), 64'd0);
      chk("p1_mult_done", 64'(bus1.done), 64'd1);
      chk("p1_mult_hilo", {bus1.hi, bus1.lo}, ref_op(4'd1, 32'd7, 32'hFFFFFFFA, 64'd0));
      bus1.start = 1'b1; bus1.op = 4'd4; bus1.d1 = 32'd100; bus1.d2 = 32'd7;
      tick();
      bus1.start = 1'b0; bus1.op = 4'd0;
      chk("p1_divu_busy", 64'(bus1.busy), 64'd1);
      tick();
      chk("p1_divu_fall", 64'(bus1.busy), 64'd0);
      chk("p1_divu_hilo", {bus1.hi, bus1.lo}, 64'h00000002_0000000E);
      tick();
      chk("p1_done_pulse", 64'(bus1.done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
